// File: rtl/ramp_adc_capture_if.sv
// Ramp-ADC capture bundle: ramp code out, comparator in, and the sample valid/ready channel.
// The master side is the capture controller; the slave side is the front end plus the consumer.
interface ramp_adc_capture_if #(
    parameter int WIDTH = 8
) ();
    logic             enable;
    logic             comparator_in;
    logic [WIDTH-1:0] pwm_duty;
    logic [WIDTH-1:0] sample;
    logic             sample_valid;
    logic             sample_ready;
    logic             overrange;
    logic             sample_dropped;
    logic             busy;

    modport master (
        input  enable, comparator_in, sample_ready,
        output pwm_duty, sample, sample_valid, overrange, sample_dropped, busy
    );

    modport slave (
        output enable, comparator_in, sample_ready,
        input  pwm_duty, sample, sample_valid, overrange, sample_dropped, busy
    );
endinterface

// File: rtl/ramp_adc_capture.sv
// Ramp-ADC controller: steps a PWM ramp, judges a synchronised comparator after each settle
// window, averages 2^AVG_LOG2 trip codes and publishes them on a valid/ready channel.
module ramp_adc_capture #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 64,
    parameter int SYNC_STAGES   = 2,
    parameter int AVG_LOG2      = 2
) (
    input  logic                clk,
    input  logic                reset,
    ramp_adc_capture_if.master  bus
);
    localparam int SC_W  = $clog2(SETTLE_CYCLES);
    localparam int ACC_W = WIDTH + AVG_LOG2;
    localparam int SWP_W = AVG_LOG2 + 1;
    localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [SWP_W-1:0] SWEEPS      = SWP_W'(1 << AVG_LOG2);
    localparam logic [WIDTH-1:0] CODE_MAX    = '1;

    typedef enum logic [1:0] {IDLE, SWEEP, PUBLISH} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] comp_sync;
    logic [SC_W-1:0]        settle_cnt;
    logic [SWP_W-1:0]       sweep_cnt;
    logic [ACC_W-1:0]       acc;
    logic                   ovr_acc;
    logic [WIDTH-1:0]       pwm_duty;
    logic [WIDTH-1:0]       sample;
    logic                   sample_valid;
    logic                   overrange;
    logic                   sample_dropped;
    logic                   busy;

    logic                   comp_s;
    logic                   at_max;
    logic                   trip;
    logic [ACC_W-1:0]       acc_add;
    logic [SWP_W-1:0]       sweep_nxt;

    // A trip is either the comparator flipping low or the ramp running out of codes.
    assign comp_s    = comp_sync[SYNC_STAGES-1];
    assign at_max    = (pwm_duty == CODE_MAX);
    assign trip      = !comp_s || at_max;
    assign acc_add   = acc + ACC_W'(pwm_duty);
    assign sweep_nxt = sweep_cnt + SWP_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            comp_sync      <= '0;
            settle_cnt     <= '0;
            sweep_cnt      <= '0;
            acc            <= '0;
            ovr_acc        <= 1'b0;
            pwm_duty       <= '0;
            sample         <= '0;
            sample_valid   <= 1'b0;
            overrange      <= 1'b0;
            sample_dropped <= 1'b0;
            busy           <= 1'b0;
        end else begin
            comp_sync      <= {comp_sync[SYNC_STAGES-2:0], bus.comparator_in};
            sample_dropped <= 1'b0;
            if (sample_valid && bus.sample_ready)
                sample_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        state      <= SWEEP;
                        busy       <= 1'b1;
                        pwm_duty   <= '0;
                        settle_cnt <= '0;
                    end
                end
                SWEEP: begin
                    if (!bus.enable) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        pwm_duty   <= '0;
                        settle_cnt <= '0;
                        acc        <= '0;
                        ovr_acc    <= 1'b0;
                        sweep_cnt  <= '0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        if (trip) begin
                            acc       <= acc_add;
                            pwm_duty  <= '0;
                            sweep_cnt <= sweep_nxt;
                            if (comp_s && at_max)
                                ovr_acc <= 1'b1;
                            if (sweep_nxt == SWEEPS)
                                state <= PUBLISH;
                        end else begin
                            pwm_duty <= pwm_duty + WIDTH'(1);
                        end
                    end else begin
                        settle_cnt <= settle_cnt + SC_W'(1);
                    end
                end
                PUBLISH: begin
                    // Publishing over an unread sample loses it; a same-cycle read is not a loss.
                    sample       <= WIDTH'(acc >> AVG_LOG2);
                    overrange    <= ovr_acc;
                    sample_valid <= 1'b1;
                    if (sample_valid && !bus.sample_ready)
                        sample_dropped <= 1'b1;
                    acc        <= '0;
                    ovr_acc    <= 1'b0;
                    sweep_cnt  <= '0;
                    settle_cnt <= '0;
                    pwm_duty   <= '0;
                    if (bus.enable) begin
                        state <= SWEEP;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pwm_duty       = pwm_duty;
    assign bus.sample         = sample;
    assign bus.sample_valid   = sample_valid;
    assign bus.overrange      = overrange;
    assign bus.sample_dropped = sample_dropped;
    assign bus.busy           = busy;
endmodule

// File: tb/tb_ramp_adc_capture.sv
// Directed bench for ramp_adc_capture (WIDTH=8, SETTLE_CYCLES=4, SYNC_STAGES=2, AVG_LOG2=2);
// the comparator front end is modelled as (pwm_duty < thresh).
module tb_ramp_adc_capture;
    logic clk = 1'b0;
    logic reset;
    int   thresh;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   c0;
    int   tr [4] = '{10, 11, 12, 14};

    ramp_adc_capture_if #(.WIDTH(8)) bus ();

    ramp_adc_capture #(
        .WIDTH(8), .SETTLE_CYCLES(4), .SYNC_STAGES(2), .AVG_LOG2(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.comparator_in = (int'(bus.pwm_duty) < thresh);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_pwm(input int v, input int budget, input string tag);
        int  n = 0;
        bit  hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            if (int'(bus.pwm_duty) == v) hit = 1'b1;
        end
        check_val(tag, 32'(hit), 32'd1);
    endtask

    // sel 0 waits for sample_valid, sel 1 for sample_dropped.
    task automatic wait_flag(input int sel, input int budget, input string tag);
        int  n = 0;
        bit  hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            if ((sel == 0) ? bus.sample_valid : bus.sample_dropped) hit = 1'b1;
        end
        check_val(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        reset            = 1'b1;
        bus.enable       = 1'b0;
        bus.sample_ready = 1'b0;
        thresh           = 100;
        repeat (3) @(negedge clk);
        check_val("rst_pwm",     32'(bus.pwm_duty),       32'd0);
        check_val("rst_sample",  32'(bus.sample),         32'd0);
        check_val("rst_valid",   32'(bus.sample_valid),   32'd0);
        check_val("rst_ovr",     32'(bus.overrange),      32'd0);
        check_val("rst_dropped", 32'(bus.sample_dropped), 32'd0);
        check_val("rst_busy",    32'(bus.busy),           32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_val("idle_busy", 32'(bus.busy), 32'd0);

        // Steady trip at 100, consumer always ready.
        bus.sample_ready = 1'b1;
        bus.enable       = 1'b1;
        wait_flag(0, 2000, "t1_valid_a");
        c0 = cyc;
        check_val("t1_sample", 32'(bus.sample),    32'd100);
        check_val("t1_ovr",    32'(bus.overrange), 32'd0);
        check_val("t1_busy",   32'(bus.busy),      32'd1);
        @(negedge clk);
        check_val("t1_valid_pulse", 32'(bus.sample_valid), 32'd0);
        wait_flag(0, 2000, "t1_valid_b");
        check_val("t1_period",   32'(cyc - c0),     32'd1617);
        check_val("t1_sample_b", 32'(bus.sample),   32'd100);

        // Four different trip codes averaged and truncated.
        bus.enable = 1'b0;
        @(negedge clk);
        check_val("t2_idle_pwm",  32'(bus.pwm_duty), 32'd0);
        check_val("t2_idle_busy", 32'(bus.busy),     32'd0);
        thresh     = tr[0];
        bus.enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            thresh = tr[i];
            wait_pwm(tr[i], 200, "t2_reach");
            wait_pwm(0, 20, "t2_trip");
        end
        wait_flag(0, 50, "t2_valid");
        check_val("t2_sample", 32'(bus.sample),    32'd11);
        check_val("t2_ovr",    32'(bus.overrange), 32'd0);

        // Comparator never trips: full-scale overrange and ramp wrap.
        bus.enable = 1'b0;
        @(negedge clk);
        thresh     = 256;
        bus.enable = 1'b1;
        wait_pwm(255, 1100, "t3_reach_max");
        repeat (3) @(negedge clk);
        check_val("t3_hold_max", 32'(bus.pwm_duty), 32'd255);
        @(negedge clk);
        check_val("t3_wrap", 32'(bus.pwm_duty), 32'd0);
        wait_flag(0, 4200, "t3_valid");
        check_val("t3_sample", 32'(bus.sample),    32'd255);
        check_val("t3_ovr",    32'(bus.overrange), 32'd1);

        // Consumer stalled across two publishes.
        bus.enable = 1'b0;
        @(negedge clk);
        bus.sample_ready = 1'b0;
        thresh           = 5;
        bus.enable       = 1'b1;
        wait_flag(0, 200, "t4_valid");
        check_val("t4_sample_a", 32'(bus.sample),         32'd5);
        check_val("t4_ovr_a",    32'(bus.overrange),      32'd0);
        check_val("t4_nodrop",   32'(bus.sample_dropped), 32'd0);
        thresh = 7;
        wait_flag(1, 200, "t4_drop");
        check_val("t4_drop_valid", 32'(bus.sample_valid), 32'd1);
        check_val("t4_sample_b",   32'(bus.sample),       32'd7);
        @(negedge clk);
        check_val("t4_drop_pulse", 32'(bus.sample_dropped), 32'd0);
        check_val("t4_valid_hold", 32'(bus.sample_valid),   32'd1);
        bus.sample_ready = 1'b1;
        @(negedge clk);
        check_val("t4_consumed", 32'(bus.sample_valid), 32'd0);

        // Abort mid-sweep after two complete sweeps; partial average must be discarded.
        bus.enable = 1'b0;
        @(negedge clk);
        thresh     = 50;
        bus.enable = 1'b1;
        wait_pwm(50, 300, "t5_reach_a");
        wait_pwm(0, 10, "t5_trip_a");
        wait_pwm(50, 300, "t5_reach_b");
        wait_pwm(0, 10, "t5_trip_b");
        wait_pwm(30, 200, "t5_mid");
        bus.enable = 1'b0;
        @(negedge clk);
        check_val("t5_abort_pwm",  32'(bus.pwm_duty), 32'd0);
        check_val("t5_abort_busy", 32'(bus.busy),     32'd0);
        repeat (5) @(negedge clk);
        check_val("t5_idle_pwm", 32'(bus.pwm_duty), 32'd0);
        thresh     = 20;
        bus.enable = 1'b1;
        wait_flag(0, 400, "t5_valid");
        check_val("t5_sample", 32'(bus.sample), 32'd20);

        // Asynchronous reset between clock edges, then restart from code 0.
        bus.sample_ready = 1'b0;
        wait_flag(0, 400, "t6_valid_pre");
        wait_pwm(10, 100, "t6_mid");
        #2;
        reset = 1'b1;
        #1;
        check_val("t6_pwm",     32'(bus.pwm_duty),       32'd0);
        check_val("t6_sample",  32'(bus.sample),         32'd0);
        check_val("t6_valid",   32'(bus.sample_valid),   32'd0);
        check_val("t6_ovr",     32'(bus.overrange),      32'd0);
        check_val("t6_dropped", 32'(bus.sample_dropped), 32'd0);
        check_val("t6_busy",    32'(bus.busy),           32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        c0    = cyc;
        @(negedge clk);
        check_val("t6_restart_pwm",  32'(bus.pwm_duty), 32'd0);
        check_val("t6_restart_busy", 32'(bus.busy),     32'd1);
        wait_flag(0, 400, "t6_valid_post");
        check_val("t6_latency",     32'(cyc - c0),    32'd338);
        check_val("t6_sample_post", 32'(bus.sample),  32'd20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
